// File: rtl/pattern_pkg.sv
// Shared types and defaults for the pattern counting engine.
package pattern_pkg;

  // Controller states; the encoding is visible on the engine's debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_PW     = 5;
  localparam int DEF_NBYTES = 32;
  localparam int DEF_CW     = 16;

  // Smallest counter width that can hold 8*nbytes window matches.
  function automatic int count_width(input int nbytes);
    return $clog2(8 * nbytes + 1);
  endfunction

endpackage

// File: rtl/window_matcher.sv
// Combinational window matcher for one byte of the bit string.
// win = {prev, b}: b in win[7:0], the low PW-1 bits of the previous byte above it.
// Window j (j = 0..7) is win[j+PW-1:j], i.e. the PW bits ending at b[j].
// Windows with j <= 8-PW lie wholly inside b; the rest reach into prev and
// only count toward the cross count, and never on the first byte.
module window_matcher
  import pattern_pkg::*;
#(
  parameter int PW = DEF_PW
) (
  input  logic [PW+6:0] win,
  input  logic [PW-1:0] pat,
  input  logic          first,
  output logic [3:0]    inb_cnt,
  output logic          any_match,
  output logic [3:0]    crs_cnt
);

  localparam int LAST_INB = 8 - PW;

  logic [3:0] xtra_cnt;

  // Count in-byte and byte-straddling matches over the eight windows.
  always_comb begin
    inb_cnt  = 4'd0;
    xtra_cnt = 4'd0;
    for (int j = 0; j < 8; j++) begin
      if (win[j +: PW] == pat) begin
        if (j <= LAST_INB) begin
          inb_cnt = inb_cnt + 4'd1;
        end else if (!first) begin
          xtra_cnt = xtra_cnt + 4'd1;
        end
      end
    end
    any_match = (inb_cnt != 4'd0);
    crs_cnt   = inb_cnt + xtra_cnt;
  end

endmodule

// File: rtl/pattern_count_engine.sv
// Pattern counting engine: streams len bytes from a synchronous memory
// starting at base, one byte per cycle, and counts PW-bit pattern matches
// inside bytes, bytes with any match, and matches over the whole bit string.
//
// Handshake: init is a request sampled only while the engine is idle
// (IDLE, or DONE once done is high); the accepting edge clears the counts
// and latches pat/len/base. busy is high from that edge until done rises;
// done is a level that stays high until the next accepted init. An init
// seen while busy is dropped.
//
// Timing: the accepting edge T loads mem_addr=base; the memory returns
// byte i in the cycle ending at edge T+2+i, where it is consumed. done is a
// registered acknowledge that rises one edge after the FSM enters DONE, so
// it is high from T+len+2 (T+2 for len=0).
module pattern_count_engine
  import pattern_pkg::*;
#(
  parameter int PW     = DEF_PW,
  parameter int NBYTES = DEF_NBYTES,
  parameter int AW     = 8,
  parameter int CW     = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [PW-1:0] pat,
  input  logic [7:0]    len,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [CW-1:0] cnt_inb,
  output logic [CW-1:0] cnt_byt,
  output logic [CW-1:0] cnt_crs,
  output logic          busy,
  output logic          done,
  output state_t        state_dbg
);

  localparam logic [7:0] NB_MAX = 8'(NBYTES);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] pat_q;
  logic [7:0]    len_q;
  logic [7:0]    idx_q;
  logic [7:0]    len_clamped;

  logic          accept;
  logic          scan_en;
  logic          first_byte;
  logic          last_byte;

  logic [PW+6:0] win;
  logic [3:0]    m_inb;
  logic          m_any;
  logic [3:0]    m_crs;

  assign state_dbg   = state_q;
  assign len_clamped = (len > NB_MAX) ? NB_MAX : len;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: state_d = (len_q == 8'd0) ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (last_byte) state_d = ST_DONE;
      ST_DONE:  if (accept) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State-decoded control strobes.
  always_comb begin
    accept     = init && !busy && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    scan_en    = (state_q == ST_SCAN);
    first_byte = (idx_q == 8'd0);
    last_byte  = (idx_q == (len_q - 8'd1));
  end

  // Job parameters are captured only on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= '0;
      len_q <= 8'd0;
    end else if (accept) begin
      pat_q <= pat;
      len_q <= len_clamped;
    end
  end

  // Read address: loaded from base on accept, then advances every cycle
  // while fetching or scanning; wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr <= '0;
    end else if (accept) begin
      mem_addr <= base;
    end else if ((state_q == ST_FETCH) || (state_q == ST_SCAN)) begin
      mem_addr <= mem_addr + AW'(1);
    end
  end

  // Index of the byte currently on mem_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= 8'd0;
    end else if (accept) begin
      idx_q <= 8'd0;
    end else if (scan_en) begin
      idx_q <= idx_q + 8'd1;
    end
  end

  // Tail of the previous byte feeds the byte-straddling windows.
  generate
    if (PW > 1) begin : g_prev
      logic [PW-2:0] prev_q;

      // Keep the low PW-1 bits of each consumed byte.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          prev_q <= '0;
        end else if (accept) begin
          prev_q <= '0;
        end else if (scan_en) begin
          prev_q <= mem_rdata[PW-2:0];
        end
      end

      assign win = {prev_q, mem_rdata};
    end else begin : g_noprev
      assign win = mem_rdata;
    end
  endgenerate

  window_matcher #(
    .PW (PW)
  ) u_matcher (
    .win       (win),
    .pat       (pat_q),
    .first     (first_byte),
    .inb_cnt   (m_inb),
    .any_match (m_any),
    .crs_cnt   (m_crs)
  );

  // Result counters: cleared on accept, accumulate one byte per scan cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_inb <= '0;
      cnt_byt <= '0;
      cnt_crs <= '0;
    end else if (accept) begin
      cnt_inb <= '0;
      cnt_byt <= '0;
      cnt_crs <= '0;
    end else if (scan_en) begin
      cnt_inb <= cnt_inb + CW'(m_inb);
      cnt_byt <= cnt_byt + CW'(m_any);
      cnt_crs <= cnt_crs + CW'(m_crs);
    end
  end

  // busy/done: done rises one edge after DONE is entered, busy falls with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (accept) begin
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state_q == ST_DONE) begin
      busy <= 1'b0;
      done <= 1'b1;
    end
  end

endmodule

// File: doc/pattern_count_engine.md
PATTERN_COUNT_ENGINE -- requirements
Module: pattern_count_engine

Interface
REQ-001 SHALL have parameter PW, default 5: pattern width in bits, legal 1..8.
REQ-002 SHALL have parameter NBYTES, default 32: maximum string length in bytes, legal 1..255.
REQ-003 SHALL have parameter AW, default 8: memory address width.
REQ-004 SHALL have parameter CW, default 16: result counter width; CW >= clog2(8*NBYTES+1).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 init  input  1  start request, sampled only in IDLE.
REQ-008 pat  input  PW  pattern; latched on accepted init.
REQ-009 len  input  8  string length in bytes; latched on accepted init; values above NBYTES are clamped to NBYTES.
REQ-010 base  input  AW  first byte address; latched on accepted init.
REQ-011 mem_addr  output  AW  read address to synchronous data memory.
REQ-012 mem_rdata  input  8  read data, valid exactly one cycle after mem_addr.
REQ-013 cnt_inb  output  CW  in-byte pattern matches; windows do not cross byte boundaries.
REQ-014 cnt_byt  output  CW  number of bytes containing at least one in-byte match.
REQ-015 cnt_crs  output  CW  pattern matches over the whole bit string; windows may cross byte boundaries.
REQ-016 busy  output  1  high from the accepted init until done.
REQ-017 done  output  1  level acknowledge; high in DONE until the next accepted init.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, SCAN and DONE.
REQ-019 The FSM SHALL use these transitions: IDLE->FETCH on init; FETCH->SCAN; SCAN->DONE after the last byte; DONE->FETCH on init.
REQ-020 If the latched len is 0, the FSM SHALL go FETCH->DONE with all counts 0.
REQ-021 On an accepted init, the block SHALL clear all counts to 0 in the same edge.
REQ-022 The string is bytes base..base+len-1. Byte 0 is the most significant. Bit 7 is first within each byte.
REQ-023 The block SHALL sustain one byte per cycle throughput, with mem_addr advancing by 1 every cycle from FETCH onward.
REQ-024 mem_addr SHALL wrap modulo 2^AW.
REQ-025 Timing: if init is sampled at edge T, done SHALL be high from edge T+len+2 and counts SHALL be final at that edge; with len=0, done SHALL be high at edge T+2.
REQ-026 Per byte b, the block SHALL compare all 9-PW windows b[PW-1+k:k], k=0..8-PW, against pat.
  - cnt_inb += number of window matches.
  - cnt_byt += 1 if any window matches.
REQ-027 Cross count: the block SHALL keep prev = the low PW-1 bits of the previous byte and form {prev,b} (PW+7 bits).
  - Evaluate the 8 windows ending at each bit of b.
  - For the first byte, only windows lying wholly inside b are valid (9-PW windows).
  - cnt_crs += number of valid matches.
  - Total windows counted = 8*len-PW+1.
REQ-028 When PW=1, prev is empty and cnt_crs SHALL equal cnt_inb.
REQ-029 The counters SHALL never overflow given the CW rule in REQ-004; no saturation logic is required.
REQ-030 An init asserted while busy SHALL be ignored, with no restart and no effect on pat, len or base.
REQ-031 The counts SHALL hold their values in DONE and IDLE.
REQ-032 Counts, pat, len and base SHALL remain unchanged during SCAN regardless of any change on the pat, len or base inputs.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force state IDLE, mem_addr=0, all counts 0, busy=0, done=0 and prev=0.
REQ-034 A reset during FETCH or SCAN SHALL abort the scan, with no partial results retained.
REQ-035 After reset is released, the first init SHALL be honoured on the first rising edge.

Structure
REQ-036 The shared package pattern_pkg SHALL hold the state enum type, the default PW, NBYTES and CW values, and a count-width helper function.
REQ-037 A single sub-module, window_matcher (parameter PW), SHALL compute the in-byte match count, any-match flag and cross-window match count from {prev,b}, pat and a first-byte flag.
REQ-038 window_matcher SHALL be purely combinational; all registers SHALL reside in pattern_count_engine.

Verification
REQ-039 Scenario PW=5, len=32, all bytes 8'h00, pat=5'b00000 -> cnt_inb=128, cnt_byt=32, cnt_crs=252, done at T+34.
REQ-040 Scenario PW=5, len=32, all bytes 8'h55, pat=5'b10101 -> cnt_inb=64, cnt_byt=32, cnt_crs=126.
REQ-041 Scenario PW=3, len=4, all bytes 8'hFF, pat=3'b111 -> cnt_inb=24, cnt_byt=4, cnt_crs=30.
REQ-042 Scenario len=0 -> done at T+2, all counts 0, mem_rdata never consumed.
REQ-043 Scenario: reset=0 pulse at byte 10 of a 32-byte scan, then init again with different pat -> outputs are 0 during reset, and the second run's results match a software model.
REQ-044 Scenario: init re-pulsed mid-scan; then 64 random runs (random pat, len, base near 2^AW-1) -> the re-pulse is ignored, and every run's three counts match a reference model, including address wrap.
